// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its consumers.
package fetch_pkg;

  localparam int FetchMaxInflight = 2;

  // One instruction FIFO entry: the fetch PC alongside the fetched word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's redirect, memory and FIFO signals for the environment side.
// Handshake: a memory request transfers on a cycle where mem_valid && mem_ready; once raised,
// mem_valid and mem_addr hold until that transfer unless a redirect withdraws them.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fifo_valid;
  logic [63:0] fifo_data;
  logic        fifo_ready;
  logic        fifo_ready_two;

  // Fetch side: issues requests, writes the FIFO.
  modport master (
    input  redirect_valid, redirect_pc, mem_ready, mem_rvalid, mem_rdata,
           fifo_ready, fifo_ready_two,
    output mem_valid, mem_addr, fifo_valid, fifo_data
  );

  // Memory / FIFO / control side.
  modport slave (
    output redirect_valid, redirect_pc, mem_ready, mem_rvalid, mem_rdata,
           fifo_ready, fifo_ready_two,
    input  mem_valid, mem_addr, fifo_valid, fifo_data
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word reads under a FIFO credit rule and forwards in-order
// responses straight into the instruction FIFO, dropping responses owed to a stale stream.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] ResetVector = 32'h0000_0000,
  parameter int          MaxInflight = FetchMaxInflight
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fifo_valid_o,
  output logic [63:0] fifo_data_o,
  input  logic        fifo_ready_i,
  input  logic        fifo_ready_two_i
);

  localparam logic [1:0] MaxCnt = 2'(MaxInflight);

  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [1:0]  inflight_q, inflight_d;
  logic [1:0]  discard_q, discard_d;
  logic        hold_q, hold_d;

  logic         credit_ok;
  logic         accept;
  logic         resp;
  logic         fresh;
  logic [31:0]  redirect_target;
  fetch_entry_t entry;

  assign redirect_target = word_align(redirect_pc_i);

  // A request may only issue if the FIFO can absorb its response plus any still in flight.
  assign credit_ok = ((inflight_q == 2'd0) && fifo_ready_i) ||
                     ((inflight_q == 2'd1) && fifo_ready_two_i);

  // hold_q keeps an unaccepted request up even if the credit inputs drop meanwhile.
  assign mem_valid_o = !rst_i && !redirect_valid_i && (inflight_q != MaxCnt) &&
                       (hold_q || credit_ok);
  assign mem_addr_o  = req_pc_q;
  assign accept      = mem_valid_o && mem_ready_i;

  // With nothing outstanding a response is a leftover from before reset and is ignored.
  assign resp  = !rst_i && mem_rvalid_i && (inflight_q != 2'd0);
  assign fresh = resp && (discard_q == 2'd0) && !redirect_valid_i;

  assign entry        = '{pc: resp_pc_q, instr: mem_rdata_i};
  assign fifo_valid_o = fresh;
  assign fifo_data_o  = entry;

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !resp) begin
      inflight_d = inflight_q + 2'd1;
    end else if (!accept && resp) begin
      inflight_d = inflight_q - 2'd1;
    end

    req_pc_d  = accept ? req_pc_q + 32'd4 : req_pc_q;
    resp_pc_d = fresh ? resp_pc_q + 32'd4 : resp_pc_q;

    discard_d = discard_q;
    if (resp && (discard_q != 2'd0)) begin
      discard_d = discard_q - 2'd1;
    end

    hold_d = mem_valid_o && !mem_ready_i;

    // Every request still outstanding after this cycle belongs to the old stream.
    if (redirect_valid_i) begin
      req_pc_d  = redirect_target;
      resp_pc_d = redirect_target;
      discard_d = inflight_d;
      hold_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc_q   <= ResetVector;
      resp_pc_q  <= ResetVector;
      inflight_q <= 2'd0;
      discard_q  <= 2'd0;
      hold_q     <= 1'b0;
    end else begin
      req_pc_q   <= req_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
    end
  end

endmodule
